led_flow_sequencer: RTL

Controller for the LED flow-light shift datapath, running on the board system clock. It conditions the raw start/stop button and the direction switch, and runs an IDLE/RUN/PAUSE state machine. It issues single-cycle step enables at a selectable rate, so the shifter advances exactly one position per step_pulse. It also requests a pattern reload (led_clear) on a soft clear.

---
 rtl/led_flow_pkg.sv | 13 +
 rtl/led_flow_sequencer_btn_debounce.sv | 56 +++++
 rtl/led_flow_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/led_flow_pkg.sv
// rtl/led_flow_pkg.sv - shared types and constants for the LED flow-light sequencer
package led_flow_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_e;

    localparam logic [7:0] LED_INIT = 8'b0000_0001;
    localparam int         SPEED_W  = 2;

endpackage

// File: rtl/led_flow_sequencer_btn_debounce.sv
// rtl/led_flow_sequencer_btn_debounce.sv - button synchronizer, debouncer and press edge detector
module btn_debounce #(
    parameter int DB_CYCLES = 2_000_000,
    parameter int CNT_W     = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             meta_q,   meta_d;
    logic             sync_q,   sync_d;
    logic             stable_q, stable_d;
    logic             press_q,  press_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    // The counter only runs while the synchronized level disagrees with the
    // accepted level, so any bounce shorter than DB_CYCLES is forgotten.
    always_comb begin
        meta_d   = btn_raw;
        sync_d   = meta_q;
        stable_d = stable_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == DB_LAST) begin
                stable_d = sync_q;
                press_d  = sync_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            meta_q   <= meta_d;
            sync_q   <= sync_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/led_flow_sequencer.sv
// rtl/led_flow_sequencer.sv - IDLE/RUN/PAUSE controller issuing step pulses and direction to the LED shifter
module led_flow_sequencer
    import led_flow_pkg::*;
#(
    parameter int DB_CYCLES = 2_000_000,
    parameter int STEP_CYC  = 25_000_000,
    parameter int CNT_W     = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn_raw,
    input  logic               dir_sw,
    input  logic [SPEED_W-1:0] speed_sel,
    input  logic               soft_clr,
    output logic               step_pulse,
    output logic               dir_left,
    output logic               running,
    output logic               led_clear,
    output logic [1:0]         state
);

    localparam logic [CNT_W-1:0] STEP_P = CNT_W'(STEP_CYC);

    logic             press;
    logic             dir_meta_q, dir_meta_d;
    logic             dir_sync_q, dir_sync_d;
    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             step_q,     step_d;
    logic             dir_q,      dir_d;
    logic             run_q,      run_d;
    logic             clr_q,      clr_d;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] term;
    logic             step_fire;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_btn (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_raw),
        .press   (press)
    );

    assign period = STEP_P >> speed_sel;
    assign term   = period - CNT_W'(1);

    // Comparing with >= lets a speed-up that lands below the current count
    // fire once immediately instead of waiting for a full counter wrap.
    always_comb begin
        dir_meta_d = dir_sw;
        dir_sync_d = dir_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        dir_d      = dir_sync_q;
        clr_d      = soft_clr;
        step_fire  = (state_q == RUN) && !soft_clr && (cnt_q >= term);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (press) state_d = RUN;
            end
            RUN: begin
                cnt_d = step_fire ? '0 : cnt_q + CNT_W'(1);
                dir_d = step_fire ? dir_sync_q : dir_q;
                if (press) state_d = PAUSE;
            end
            PAUSE: begin
                if (press) state_d = RUN;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A soft clear wins over any press seen in the same cycle.
        if (soft_clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        step_d = step_fire;
        run_d  = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_meta_q <= 1'b0;
            dir_sync_q <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            run_q      <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            dir_meta_q <= dir_meta_d;
            dir_sync_q <= dir_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
            clr_q      <= clr_d;
        end
    end

    assign step_pulse = step_q;
    assign dir_left   = dir_q;
    assign running    = run_q;
    assign led_clear  = clr_q;
    assign state      = state_q;

endmodule
